// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the operand stage and the ALU: op codes, the
// OP / OP-IMM opcode values, the decoded-control bundle and its decoder.
package alu_operand_stage_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned REG_AW  = 5;
   localparam int unsigned ALUOP_W = 4;

   typedef enum logic [ALUOP_W-1:0] {
      ALU_ADD = 4'b0000,
      ALU_SUB = 4'b0001,
      ALU_AND = 4'b0010,
      ALU_OR  = 4'b0011,
      ALU_XOR = 4'b0100,
      ALU_SLT = 4'b0101   // unsigned compare
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   // Control part of an operand bundle (data words carried separately).
   typedef struct packed {
      alu_op_e           aluop;
      logic [REG_AW-1:0] rd;
      logic              use_imm;
      logic              illegal;
   } dec_t;

   // Unsupported encodings decode to ADD with illegal set.
   function automatic dec_t decode_instr(input logic [6:0]        opcode,
                                         input logic [2:0]        funct3,
                                         input logic [6:0]        funct7,
                                         input logic [REG_AW-1:0] rd);
      dec_t    d;
      alu_op_e f3_op;
      logic    f3_ok;
      d.aluop   = ALU_ADD;
      d.rd      = rd;
      d.use_imm = 1'b0;
      d.illegal = 1'b1;
      f3_ok     = 1'b1;
      case (funct3)
         3'b000:  f3_op = ALU_ADD;
         3'b111:  f3_op = ALU_AND;
         3'b110:  f3_op = ALU_OR;
         3'b100:  f3_op = ALU_XOR;
         3'b011:  f3_op = ALU_SLT;
         default: begin
            f3_op = ALU_ADD;
            f3_ok = 1'b0;
         end
      endcase
      if (opcode == OPC_OP) begin
         if (f3_ok && funct7 == F7_BASE) begin
            d.aluop   = f3_op;
            d.illegal = 1'b0;
         end else if (funct3 == 3'b000 && funct7 == F7_ALT) begin
            d.aluop   = ALU_SUB;
            d.illegal = 1'b0;
         end
      end else if (opcode == OPC_OP_IMM && f3_ok) begin
         // OP-IMM has no SUB: bits [31:25] belong to the immediate.
         d.aluop   = f3_op;
         d.use_imm = 1'b1;
         d.illegal = 1'b0;
      end
      return d;
   endfunction

endpackage

// File: rtl/alu_operand_stage_regfile.sv
// regfile: NREGS x DATA_W register file, two async read ports, one write port.
// x0 reads as zero and ignores writes; a read of the address being written in
// the same cycle returns the write data (write-through).
// Ports: clk, rst (async, active-high), we/waddr/wdata write port,
//        raddr1/rdata1_c and raddr2/rdata2_c combinational read ports.
module regfile
   import alu_operand_stage_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NREGS  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1_c,
   input  logic [REG_AW-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2_c
);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic              wr_hit;

   assign wr_hit = we && (waddr != '0);

   // Next register contents.
   always_comb begin
      regs_d = regs_q;
      if (wr_hit) regs_d[waddr] = wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) regs_q <= '{default: '0};
      else     regs_q <= regs_d;
   end

   // Read port 1 with write-through bypass.
   always_comb begin
      rdata1_c = regs_q[raddr1];
      if (raddr1 == '0)                  rdata1_c = '0;
      else if (wr_hit && waddr == raddr1) rdata1_c = wdata;
   end

   // Read port 2 with write-through bypass.
   always_comb begin
      rdata2_c = regs_q[raddr2];
      if (raddr2 == '0)                  rdata2_c = '0;
      else if (wr_hit && waddr == raddr2) rdata2_c = wdata;
   end

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: decodes RV32 OP / OP-IMM instructions, reads operands
// from the register file and presents a registered operand bundle to the ALU
// behind a one-entry valid/ready stage with full throughput.
// Ports: clk, rst (async, active-high); in_valid/in_instr/in_ready upstream;
//        wb_en/wb_addr/wb_data writeback; out_valid/out_ready, data1, data2,
//        aluoperation, out_rd, illegal downstream.
module alu_operand_stage
   import alu_operand_stage_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NREGS  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               in_ready,
   input  logic               wb_en,
   input  logic [REG_AW-1:0]  wb_addr,
   input  logic [DATA_W-1:0]  wb_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  data1,
   output logic [DATA_W-1:0]  data2,
   output logic [ALUOP_W-1:0] aluoperation,
   output logic [REG_AW-1:0]  out_rd,
   output logic               illegal
);

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] data1_q, data1_d;
   logic [DATA_W-1:0] data2_q, data2_d;
   dec_t              dec_q, dec_d;

   logic [DATA_W-1:0] rdata1, rdata2, imm_sext;
   dec_t              dec;
   logic              take_in;

   regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .we       (wb_en),
      .waddr    (wb_addr),
      .wdata    (wb_data),
      .raddr1   (in_instr[19:15]),
      .rdata1_c (rdata1),
      .raddr2   (in_instr[24:20]),
      .rdata2_c (rdata2)
   );

   assign imm_sext = {{(DATA_W-12){in_instr[31]}}, in_instr[31:20]};
   assign dec      = decode_instr(in_instr[6:0], in_instr[14:12],
                                  in_instr[31:25], in_instr[11:7]);

   // The stage can take a word whenever it is empty or being drained.
   assign in_ready = !out_valid_q || out_ready;
   assign take_in  = in_valid && in_ready;

   // Next bundle: load on accept, drop valid on drain, otherwise hold.
   always_comb begin
      out_valid_d = out_valid_q;
      data1_d     = data1_q;
      data2_d     = data2_q;
      dec_d       = dec_q;
      if (take_in) begin
         out_valid_d = 1'b1;
         dec_d       = dec;
         if (dec.illegal) begin
            data1_d = '0;
            data2_d = '0;
         end else begin
            data1_d = rdata1;
            data2_d = dec.use_imm ? imm_sext : rdata2;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         data1_q     <= '0;
         data2_q     <= '0;
         dec_q       <= '{aluop: ALU_ADD, rd: '0, use_imm: 1'b0, illegal: 1'b0};
      end else begin
         out_valid_q <= out_valid_d;
         data1_q     <= data1_d;
         data2_q     <= data2_d;
         dec_q       <= dec_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign data1        = data1_q;
   assign data2        = data2_q;
   assign aluoperation = dec_q.aluop;
   assign out_rd       = dec_q.rd;
   assign illegal      = dec_q.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage: directed scenarios followed by random
// traffic, all checked against a behavioural model of the operand stage.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_instr;
   logic        in_ready;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] data1, data2;
   logic [3:0]  aluoperation;
   logic [4:0]  out_rd;
   logic        illegal;

   alu_operand_stage #(.DATA_W(32), .NREGS(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_instr     (in_instr),
      .in_ready     (in_ready),
      .wb_en        (wb_en),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .data1        (data1),
      .data2        (data2),
      .aluoperation (aluoperation),
      .out_rd       (out_rd),
      .illegal      (illegal)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model state: architectural registers and the bundle held by the stage.
   logic [31:0] m_regs [32];
   logic        m_valid;
   logic [31:0] m_d1, m_d2;
   logic [3:0]  m_op;
   logic [4:0]  m_rd;
   logic        m_ill;

   localparam logic [31:0] I_ADD_3_1_2  = 32'h002081B3;
   localparam logic [31:0] I_ADDI_4_1_M = 32'hFFF08213;
   localparam logic [31:0] I_SUB_5_1_2  = 32'h402082B3;
   localparam logic [31:0] I_XOR_6_1_2  = 32'h0020C333;
   localparam logic [31:0] I_ADD_7_0_0  = 32'h000003B3;
   localparam logic [31:0] I_LW_2_1     = 32'h0000A103;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: what the ALU should be told for an instruction, given the
   // operand values that register rs1/rs2 hold at issue time.
   function automatic void ref_bundle(input logic [31:0] ins, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] d1,
                                      output logic [31:0] d2, output logic [3:0] op,
                                      output logic ill);
      int          code;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      opc  = ins[6:0];
      f3   = ins[14:12];
      f7   = ins[31:25];
      imm  = 32'($signed(ins[31:20]));
      case (f3)
         3'd0:    code = 0;
         3'd7:    code = 2;
         3'd6:    code = 3;
         3'd4:    code = 4;
         3'd3:    code = 5;
         default: code = -1;
      endcase
      if (opc == 7'h33) begin
         if (f3 == 3'd0 && f7 == 7'h20) code = 1;
         else if (f7 != 7'h00)          code = -1;
      end else if (opc != 7'h13) begin
         code = -1;
      end
      if (code < 0) begin
         ill = 1'b1; op = 4'd0; d1 = '0; d2 = '0;
      end else begin
         ill = 1'b0; op = 4'(code); d1 = a;
         d2  = (opc == 7'h13) ? imm : b;
      end
   endfunction

   function automatic logic [31:0] rd_model(input logic [4:0] addr, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
      if (addr == 5'd0)          return '0;
      if (we && wa == addr)      return wd;
      return m_regs[addr];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_valid = 1'b0; m_d1 = '0; m_d2 = '0; m_op = '0; m_rd = '0; m_ill = 1'b0;
   endtask

   task automatic check_out(input string tag);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
         chk({tag, ".data1"}, data1, m_d1);
         chk({tag, ".data2"}, data2, m_d2);
         chk({tag, ".aluop"}, 32'(aluoperation), 32'(m_op));
         chk({tag, ".illegal"}, 32'(illegal), 32'(m_ill));
         if (!m_ill) chk({tag, ".out_rd"}, 32'(out_rd), 32'(m_rd));
      end
   endtask

   // One clock cycle: drive, check in_ready, advance model, check outputs.
   task automatic cyc(input string tag, input logic v, input logic [31:0] ins,
                      input logic ordy, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd);
      logic exp_rdy;
      in_valid = v; in_instr = ins; out_ready = ordy;
      wb_en = we; wb_addr = wa; wb_data = wd;
      #1;
      exp_rdy = !m_valid || ordy;
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
      if (v && exp_rdy) begin
         ref_bundle(ins, rd_model(ins[19:15], we, wa, wd), rd_model(ins[24:20], we, wa, wd),
                    m_d1, m_d2, m_op, m_ill);
         m_rd    = ins[11:7];
         m_valid = 1'b1;
      end else if (ordy) begin
         m_valid = 1'b0;
      end
      if (we && wa != 5'd0) m_regs[wa] = wd;
      @(posedge clk);
      #1;
      check_out(tag);
   endtask

   initial begin
      logic [6:0]  r_opc, r_f7;
      logic [2:0]  r_f3;
      logic [31:0] r_ins;

      rst = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      model_reset();

      // Reset state
      #2 rst = 1'b1;
      #1;
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.data1", data1, 32'd0);
      chk("rst.data2", data2, 32'd0);
      chk("rst.aluop", 32'(aluoperation), 32'd0);
      chk("rst.out_rd", 32'(out_rd), 32'd0);
      chk("rst.illegal", 32'(illegal), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("post_rst.in_ready", 32'(in_ready), 32'd1);

      // Register setup and ADD / ADDI
      cyc("wr_x1", 1'b0, '0, 1'b1, 1'b1, 5'd1, 32'd5);
      cyc("wr_x2", 1'b0, '0, 1'b1, 1'b1, 5'd2, 32'd3);
      cyc("add", 1'b1, I_ADD_3_1_2, 1'b1, 1'b0, '0, '0);
      chk("add.d1_const", data1, 32'd5);
      chk("add.d2_const", data2, 32'd3);
      chk("add.rd_const", 32'(out_rd), 32'd3);
      cyc("addi", 1'b1, I_ADDI_4_1_M, 1'b1, 1'b0, '0, '0);
      chk("addi.d2_const", data2, 32'hFFFF_FFFF);
      chk("addi.rd_const", 32'(out_rd), 32'd4);

      // Stall: held bundle unaffected by a writeback to its source
      cyc("sub", 1'b1, I_SUB_5_1_2, 1'b1, 1'b0, '0, '0);
      cyc("stall", 1'b1, I_ADD_3_1_2, 1'b0, 1'b1, 5'd1, 32'd9);
      chk("stall.d1_const", data1, 32'd5);
      chk("stall.op_const", 32'(aluoperation), 32'd1);
      chk("stall.in_ready_const", 32'(in_ready), 32'd0);
      cyc("release", 1'b1, I_ADD_3_1_2, 1'b1, 1'b0, '0, '0);
      chk("release.d1_const", data1, 32'd9);

      // Write-through and x0
      cyc("xor_wt", 1'b1, I_XOR_6_1_2, 1'b1, 1'b1, 5'd1, 32'h77);
      chk("xor_wt.d1_const", data1, 32'h77);
      cyc("wr_x0", 1'b0, '0, 1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF);
      cyc("rd_x0", 1'b1, I_ADD_7_0_0, 1'b1, 1'b1, 5'd0, 32'h1234_5678);
      chk("rd_x0.d1_const", data1, 32'd0);

      // Unsupported instruction
      cyc("load", 1'b1, I_LW_2_1, 1'b1, 1'b0, '0, '0);
      chk("load.ill_const", 32'(illegal), 32'd1);
      chk("load.d2_const", data2, 32'd0);

      // Back-to-back stream, one bundle per cycle
      for (int i = 0; i < 8; i++) begin
         cyc("stream", 1'b1, {12'(i * 3), 5'd1, 3'b000, 5'(i + 8), 7'h13}, 1'b1, 1'b0, '0, '0);
         chk("stream.valid_const", 32'(out_valid), 32'd1);
      end

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0, 1:    r_opc = 7'h33;
            2:       r_opc = 7'h13;
            default: r_opc = 7'($urandom);
         endcase
         case ($urandom_range(0, 2))
            0:       r_f7 = 7'h00;
            1:       r_f7 = 7'h20;
            default: r_f7 = 7'($urandom);
         endcase
         r_f3  = 3'($urandom);
         r_ins = {r_f7, 5'($urandom), 5'($urandom), r_f3, 5'($urandom), r_opc};
         cyc("rand", 1'($urandom_range(0, 3) != 0), r_ins, 1'($urandom_range(0, 2) != 0),
             1'($urandom), 5'($urandom), $urandom);
      end

      // Reset while a bundle is held
      cyc("pre_rst", 1'b1, I_SUB_5_1_2, 1'b0, 1'b0, '0, '0);
      #2;
      rst = 1'b1; wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hAA;
      #1;
      chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst.data1", data1, 32'd0);
      chk("mid_rst.data2", data2, 32'd0);
      chk("mid_rst.aluop", 32'(aluoperation), 32'd0);
      chk("mid_rst.out_rd", 32'(out_rd), 32'd0);
      chk("mid_rst.illegal", 32'(illegal), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0; wb_en = 1'b0;
      for (int k = 1; k < 32; k++) begin
         cyc("after_rst", 1'b1, {7'h00, 5'(k), 5'(k), 3'b000, 5'd3, 7'h33}, 1'b1, 1'b0, '0, '0);
         chk("after_rst.d1_const", data1, 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter DATA_W, default 32, operand and register width.
REQ-002 Parameter NREGS, default 32, register-file depth; address width log2(NREGS)=5.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  instruction word present.
REQ-006 in_instr  input  32  RV32 instruction (OP / OP-IMM subset).
REQ-007 in_ready  output  1  stage accepts in_instr this cycle.
REQ-008 wb_en  input  1  register write enable from writeback.
REQ-009 wb_addr  input  5  write address.
REQ-010 wb_data  input  DATA_W  write data.
REQ-011 out_valid  output  1  operand bundle valid toward ALU.
REQ-012 out_ready  input  1  downstream consumes bundle.
REQ-013 data1, data2  output  DATA_W each  ALU operands.
REQ-014 aluoperation  output  4  ALU op code.
REQ-015 out_rd  output  5  destination register.
REQ-016 illegal  output  1  bundle came from an unsupported instruction.

Function
REQ-017 Op codes SHALL be ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101 (unsigned compare).
REQ-018 Opcode 0110011 (OP): funct3 000 with funct7=0000000 -> ADD, funct7=0100000 -> SUB; 111 -> AND; 110 -> OR; 100 -> XOR; 011 -> SLT; data2 = reg[rs2].
REQ-019 Opcode 0010011 (OP-IMM): same funct3 mapping (no SUB); data2 = instr[31:20] sign-extended to DATA_W.
REQ-020 data1 SHALL always be reg[rs1] (instr[19:15]); rs2 = instr[24:20]; rd = instr[11:7].
REQ-021 Any other opcode/funct3/funct7 combination SHALL yield aluoperation=ADD, data1=data2=0, illegal=1; bundle still passes through the handshake.
REQ-022 Register x0 SHALL read as zero; writes to address 0 SHALL be ignored.
REQ-023 Write-through: a read of address A in the same cycle as wb_en with wb_addr=A (A!=0) SHALL return wb_data.
REQ-024 Latency: an instruction accepted in cycle N SHALL appear on the outputs with out_valid=1 in cycle N+1.
REQ-025 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-026 Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready.
REQ-027 While out_valid=1 and out_ready=0, all outputs SHALL hold stable; register writes during a stall SHALL NOT alter held data1/data2.
REQ-028 Simultaneous transfer out and transfer in SHALL load the new bundle with out_valid staying 1 (full throughput, no bubble).
REQ-029 Transfer out with no transfer in SHALL clear out_valid next cycle; outputs other than out_valid may hold.
REQ-030 Writeback port SHALL operate independently of the handshake state, every cycle.

Reset
REQ-031 rst asserted SHALL immediately force out_valid=0, data1=data2=0, aluoperation=0000, out_rd=0, illegal=0, all registers=0.
REQ-032 rst asserted mid-stall SHALL discard the held bundle; no writeback occurs while rst=1.
REQ-033 After rst deasserts, in_ready=1 on the first cycle.

Structure
REQ-034 ALU op-code constants and OP/OP-IMM opcode constants SHALL live in a shared package used by this block and the ALU.
REQ-035 The register file SHALL be a sub-module named regfile (2 async-read ports, 1 write port, write-through, x0 zero).

Verification
REQ-036 Reset then write x1=5, x2=3; issue ADD x3,x1,x2 (0x002081B3) -> next cycle data1=5, data2=3, aluoperation=0000, out_rd=3, out_valid=1.
REQ-037 Issue ADDI x4,x1,-1 (0xFFF08213) -> data2=0xFFFFFFFF, aluoperation=0000, out_rd=4.
REQ-038 Hold out_ready=0 with bundle SUB x5,x1,x2 held, write x1=9 -> data1 stays 5, in_ready=0; release -> next instr accepted same cycle.
REQ-039 wb_en with wb_addr=1, wb_data=0x77 in the same cycle as XOR reading x1 -> data1=0x77; write to x0 -> reads of x0 return 0.
REQ-040 Issue opcode 0000011 (load) -> illegal=1, aluoperation=0000, data1=data2=0; back-to-back valid stream with out_ready=1 -> one bundle per cycle, no gaps.
REQ-041 Assert rst while out_valid=1 -> out_valid=0 same cycle (before next edge), all registers read 0 afterwards.
